// File: rtl/fifo_frame_packer_pkg.sv
// Shared types and constants for the FIFO-to-byte-stream frame packer.
// Holds the FSM state encoding, the default start-of-frame byte and the counter width helper.
package fifo_frame_packer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SOF_TX  = 3'd1,
    REQ     = 3'd2,
    LOAD    = 3'd3,
    BYTE_TX = 3'd4,
    CSUM_TX = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // Counter width for a count of n items, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_frame_packer_if.sv
// FIFO read side plus the outgoing byte stream of the frame packer.
// The packer connects through the master modport; the FIFO/sender side uses the slave modport.
interface fifo_frame_packer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             frame_done;

  modport master (
    input  fifo_dout, fifo_empty, tx_ready,
    output fifo_rd_en, tx_data, tx_valid, busy, frame_done
  );

  modport slave (
    output fifo_dout, fifo_empty, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid, busy, frame_done
  );
endinterface

// File: rtl/fifo_frame_packer.sv
// Pops FIFO words and emits them MSB-byte-first as frames: SOF, payload words, XOR checksum.
// The byte stream uses valid/ready; data and valid hold steady while the sender stalls.
module fifo_frame_packer
  import fifo_frame_packer_pkg::*;
#(
  parameter int         WIDTH           = 32,
  parameter int         WORDS_PER_FRAME = 2,
  parameter logic [7:0] SOF             = DEFAULT_SOF
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_frame_packer_if.master   bus
);

  localparam int BYTES = WIDTH / 8;
  localparam int BCW   = cnt_width(BYTES);
  localparam int WCW   = cnt_width(WORDS_PER_FRAME);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_FRAME - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [7:0]       tx_data_reg;
  logic [7:0]       csum_reg;
  logic             tx_valid_reg;
  logic             frame_done_reg;
  logic [BCW-1:0]   byte_cnt_reg;
  logic [WCW-1:0]   word_cnt_reg;

  logic             handshake;
  logic             last_byte;
  logic             last_word;
  logic [7:0]       tx_byte;
  logic [7:0]       csum_next;
  logic [WIDTH-1:0] shift_next;

  assign handshake  = tx_valid_reg && bus.tx_ready;
  assign last_byte  = (byte_cnt_reg == LAST_BYTE);
  assign last_word  = (word_cnt_reg == LAST_WORD);
  assign shift_next = shift_reg << 8;
  assign csum_next  = csum_reg ^ tx_byte;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!bus.fifo_empty) state_next = SOF_TX;
      SOF_TX:  if (handshake) state_next = REQ;
      REQ:     if (!bus.fifo_empty) state_next = LOAD;
      LOAD:    state_next = BYTE_TX;
      BYTE_TX: if (handshake && last_byte) state_next = last_word ? CSUM_TX : REQ;
      CSUM_TX: if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Payload bytes come straight off the top of the shift register; SOF and checksum are staged.
  always_comb begin
    tx_byte        = (state_reg == BYTE_TX) ? shift_reg[WIDTH-1 -: 8] : tx_data_reg;
    bus.tx_data    = tx_byte;
    bus.tx_valid   = tx_valid_reg;
    bus.frame_done = frame_done_reg;
    bus.busy       = (state_reg != IDLE);
    bus.fifo_rd_en = (state_reg == REQ) && !bus.fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg      <= '0;
      tx_data_reg    <= '0;
      csum_reg       <= '0;
      tx_valid_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      byte_cnt_reg   <= '0;
      word_cnt_reg   <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!bus.fifo_empty) begin
            tx_data_reg  <= SOF;
            tx_valid_reg <= 1'b1;
            csum_reg     <= '0;
            word_cnt_reg <= '0;
          end
        end
        SOF_TX: begin
          if (handshake) tx_valid_reg <= 1'b0;
        end
        LOAD: begin
          shift_reg    <= bus.fifo_dout;
          byte_cnt_reg <= '0;
          tx_valid_reg <= 1'b1;
        end
        BYTE_TX: begin
          if (handshake) begin
            csum_reg  <= csum_next;
            shift_reg <= shift_next;
            if (!last_byte) begin
              byte_cnt_reg <= byte_cnt_reg + BCW'(1);
            end else if (last_word) begin
              tx_data_reg <= csum_next;
            end else begin
              word_cnt_reg <= word_cnt_reg + WCW'(1);
              tx_valid_reg <= 1'b0;
            end
          end
        end
        CSUM_TX: begin
          if (handshake) begin
            tx_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Directed bench for fifo_frame_packer: two-word frames, stalls, reset mid-frame and a one-word variant.
module tb_fifo_frame_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_frame_packer_if #(.WIDTH(32)) bus0 ();
  fifo_frame_packer_if #(.WIDTH(32)) bus1 ();

  fifo_frame_packer #(.WIDTH(32), .WORDS_PER_FRAME(2), .SOF(8'hA5)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.master)
  );
  fifo_frame_packer #(.WIDTH(32), .WORDS_PER_FRAME(1), .SOF(8'hA5)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.master)
  );

  // Simple FIFO models: data readable the cycle after a pop.
  logic [31:0] mem0 [0:31];
  logic [31:0] mem1 [0:31];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  logic hold0 = 1'b1;

  assign bus0.fifo_empty = (rd0 == wr0) || hold0;
  assign bus1.fifo_empty = (rd1 == wr1);

  always @(posedge clk) begin
    if (bus0.fifo_rd_en) begin
      bus0.fifo_dout <= mem0[rd0[4:0]];
      rd0 <= rd0 + 1;
    end
    if (bus1.fifo_rd_en) begin
      bus1.fifo_dout <= mem1[rd1[4:0]];
      rd1 <= rd1 + 1;
    end
  end

  // Byte-stream monitors.
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  int fd0 = 0, fd1 = 0, rden0 = 0, stall_err = 0, stalls = 0;
  logic stalled_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) begin
    if (!rst && bus0.tx_valid && bus0.tx_ready) got0.push_back(bus0.tx_data);
    if (!rst && bus1.tx_valid && bus1.tx_ready) got1.push_back(bus1.tx_data);
    if (bus0.frame_done) fd0 <= fd0 + 1;
    if (bus1.frame_done) fd1 <= fd1 + 1;
    if (bus0.fifo_rd_en) rden0 <= rden0 + 1;
    if (stalled_prev && !rst && !(bus0.tx_valid === 1'b1 && bus0.tx_data === prev_data))
      stall_err <= stall_err + 1;
    if (!rst && bus0.tx_valid && !bus0.tx_ready) stalls <= stalls + 1;
    stalled_prev <= !rst && bus0.tx_valid && !bus0.tx_ready;
    prev_data    <= bus0.tx_data;
  end

  int vectors = 0;
  int miscompares = 0;
  logic toggle = 1'b0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (toggle) bus0.tx_ready = ~bus0.tx_ready;
    #1;
  endtask

  task automatic wait_fd(input int which, input int target, input int budget);
    int n = 0;
    while (((which == 0) ? fd0 : fd1) < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_reached", (((which == 0) ? fd0 : fd1) >= target), 1);
  endtask

  task automatic wait_bytes(input int base, input int count, input int budget);
    int n = 0;
    while (got0.size() - base < count && n < budget) begin
      tick();
      n++;
    end
    chk("bytes_reached", (got0.size() - base >= count), 1);
  endtask

  task automatic check_seq(input int which, input string tag, input int base);
    int sz;
    sz = (which == 0) ? got0.size() : got1.size();
    chk({tag, "_len"}, sz - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < sz)
        chk($sformatf("%s_b%0d", tag, i), (which == 0) ? got0[base + i] : got1[base + i], exp_q[i]);
      else
        chk($sformatf("%s_b%0d_missing", tag, i), 1, 0);
    end
  endtask

  initial begin
    int base, fdb, rdb, seb, stb;
    bus0.tx_ready = 1'b1;
    bus1.tx_ready = 1'b1;
    repeat (3) tick();

    // Reset state.
    chk("rst_tx_valid", bus0.tx_valid, 0);
    chk("rst_tx_data", bus0.tx_data, 0);
    chk("rst_frame_done", bus0.frame_done, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_rd_en", bus0.fifo_rd_en, 0);
    chk("rst1_tx_valid", bus1.tx_valid, 0);
    rst = 1'b0;

    // Data queued but fifo_empty held: the packer must stay idle.
    mem0[wr0[4:0]] = 32'h11223344; wr0++;
    mem0[wr0[4:0]] = 32'h55667788; wr0++;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("empty_tx_valid", bus0.tx_valid, 0);
      chk("empty_busy", bus0.busy, 0);
      chk("empty_rd_en", bus0.fifo_rd_en, 0);
    end

    // Basic two-word frame at full rate.
    base = got0.size(); fdb = fd0; rdb = rden0;
    hold0 = 1'b0;
    wait_fd(0, fdb + 1, 200);
    repeat (3) tick();
    exp_q = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    check_seq(0, "full_rate", base);
    chk("full_rate_frame_done", fd0 - fdb, 1);
    chk("full_rate_rd_en_cycles", rden0 - rdb, 2);

    // Same frame with tx_ready toggling every cycle.
    mem0[wr0[4:0]] = 32'h11223344; wr0++;
    mem0[wr0[4:0]] = 32'h55667788; wr0++;
    base = got0.size(); fdb = fd0; seb = stall_err; stb = stalls;
    toggle = 1'b1;
    wait_fd(0, fdb + 1, 300);
    toggle = 1'b0;
    bus0.tx_ready = 1'b1;
    repeat (3) tick();
    check_seq(0, "toggle", base);
    chk("toggle_hold_errors", stall_err - seb, 0);
    chk("toggle_stalls_seen", (stalls > stb), 1);

    // FIFO runs dry after the first word: wait in REQ, then resume.
    mem0[wr0[4:0]] = 32'h11223344; wr0++;
    base = got0.size(); fdb = fd0;
    wait_bytes(base, 5, 100);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("dry_busy", bus0.busy, 1);
      chk("dry_tx_valid", bus0.tx_valid, 0);
      chk("dry_rd_en", bus0.fifo_rd_en, 0);
    end
    mem0[wr0[4:0]] = 32'h55667788; wr0++;
    wait_fd(0, fdb + 1, 200);
    repeat (3) tick();
    check_seq(0, "dry", base);

    // Reset after byte 0x22; the leftover word starts the next frame with a fresh checksum.
    mem0[wr0[4:0]] = 32'h11223344; wr0++;
    mem0[wr0[4:0]] = 32'h55667788; wr0++;
    base = got0.size();
    wait_bytes(base, 3, 100);
    bus0.tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_tx_valid", bus0.tx_valid, 0);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_rd_en", bus0.fifo_rd_en, 0);
    chk("midrst_partial_len", got0.size() - base, 3);
    rst = 1'b0;
    bus0.tx_ready = 1'b1;
    mem0[wr0[4:0]] = 32'hAABBCCDD; wr0++;
    base = got0.size(); fdb = fd0;
    wait_fd(0, fdb + 1, 200);
    repeat (3) tick();
    exp_q = '{8'hA5, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hCC};
    check_seq(0, "after_rst", base);

    // One word per frame, two frames back to back.
    mem1[wr1[4:0]] = 32'hDEADBEEF; wr1++;
    mem1[wr1[4:0]] = 32'h01020304; wr1++;
    base = got1.size(); fdb = fd1;
    wait_fd(1, fdb + 2, 300);
    repeat (3) tick();
    exp_q = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22,
              8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    check_seq(1, "one_word", base);
    chk("one_word_frame_done", fd1 - fdb, 2);
    chk("one_word_idle_busy", bus1.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
Downstream consumer of the single-entry FIFO on its read side. Pops WIDTH-bit words from the FIFO and serialises them MSB-byte-first into framed byte messages: SOF byte, WORDS_PER_FRAME payload words, then an XOR checksum byte. Output is a byte stream with valid/ready handshake towards the sender (UART/MAC byte interface). Runs entirely in the FIFO read-clock domain.

Parameters:
WIDTH, 32, FIFO word width; must be a multiple of 8; BYTES = WIDTH/8
WORDS_PER_FRAME, 2, payload words per frame; at least 1
SOF, 8'hA5, start-of-frame byte

Ports:
clk  input  1  clock, same clock as the FIFO read side
rst  input  1  synchronous, active-high reset
fifo_dout  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO pop request
tx_data  output  8  byte to sender
tx_valid  output  1  tx_data valid
tx_ready  input  1  sender accepts byte
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse on checksum byte handshake

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; tx_valid=0, tx_data=0, frame_done=0, busy=0, csum=0, word_cnt=0, byte_cnt=0. fifo_rd_en is 0 while in IDLE. Reset mid-frame abandons the partial frame; a word already popped is lost; no checksum is sent.
- Handshake: a byte transfers on a cycle with tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data must hold stable and tx_valid must stay high. tx_valid never drops without a handshake except on reset.
- fifo_rd_en = (state==REQ) && !fifo_empty. This is combinational and is never asserted when fifo_empty=1.
- IDLE: when fifo_empty=0, load tx_data=SOF, tx_valid=1, csum=0, word_cnt=0, and go to SOF_TX. Nothing is popped in IDLE.
- SOF_TX: on handshake, tx_valid=0 and go to REQ.
- REQ: if fifo_empty=0, pop (fifo_rd_en=1) and go to LOAD. Otherwise stay in REQ; a frame may stall indefinitely here.
- LOAD: capture fifo_dout into shift register, byte_cnt=0, tx_data=fifo_dout[WIDTH-1:WIDTH-8], tx_valid=1, go to BYTE_TX.
- BYTE_TX: on handshake:
  - csum ^= tx_data; shift left by 8.
  - If byte_cnt != BYTES-1: byte_cnt++ and present the next byte in the following cycle, with no bubble.
  - If byte_cnt == BYTES-1 and word_cnt == WORDS_PER_FRAME-1: tx_data = final csum (including this byte), tx_valid=1, go to CSUM_TX.
  - Otherwise (last byte, more words to come): word_cnt++, tx_valid=0, go to REQ.
- CSUM_TX: on handshake, tx_valid=0, frame_done=1 for exactly that next cycle, go to IDLE.
- Checksum covers payload bytes only; SOF is excluded.
- Throughput: with tx_ready=1 and the FIFO always non-empty, one byte per cycle inside a word. There are 2 bubble cycles (REQ, LOAD) between words and between SOF and the first word. IDLE costs 1 cycle after each frame.
- Counters: byte_cnt is $clog2(BYTES) bits, minimum 1. word_cnt is $clog2(WORDS_PER_FRAME) bits, minimum 1. Neither wraps outside the transitions above.
- fifo_empty rising during BYTE_TX has no effect until the next REQ.

Decomposition:
- Shared package: state enum (IDLE, SOF_TX, REQ, LOAD, BYTE_TX, CSUM_TX), default SOF constant, and a helper for the counter widths.
- No sub-module required. The byte serialiser (shift register + byte_cnt) may be split out as fifo_byte_serializer if reused by other send paths.

Test Plan:
- WIDTH=32, WORDS=2, tx_ready=1, FIFO holds 0x11223344 then 0x55667788 -> bytes A5 11 22 33 44 55 66 77 88 88 (csum 0x88); frame_done pulses once; fifo_rd_en high exactly 2 cycles.
- Same data, tx_ready toggling 1/0 each cycle -> identical byte sequence; tx_data stable and tx_valid high during every ready=0 cycle.
- FIFO empty for 20 cycles after the first word -> packer waits in REQ with busy=1, tx_valid=0, fifo_rd_en=0; resumes correctly when 0x55667788 arrives; csum still 0x88.
- rst asserted after byte 0x22 -> next cycle tx_valid=0, busy=0, fifo_rd_en=0; next frame starts with A5 and its csum is computed from zero.
- WORDS_PER_FRAME=1, words 0xDEADBEEF, 0x01020304 back-to-back -> A5 DE AD BE EF 22, then A5 01 02 03 04 04; two frame_done pulses.
- fifo_empty held 1 after reset -> tx_valid, fifo_rd_en and busy remain 0 indefinitely.
